// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the memory-access stage.
//   mem_op_e : memory op codes (codes above SW decode to NONE)
//   state_e  : stage FSM states
//   BE_*     : byte-enable patterns used for store lane generation
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_ALL = 4'b1111;

  // Unused encodings behave as a plain ALU pass-through.
  function automatic mem_op_e decode_op(input logic [3:0] code);
    return (code > 4'd8) ? OP_NONE : mem_op_e'(code);
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: selects and extends the addressed byte/half of a read word.
//   rdata : raw 32-bit word from memory
//   off   : address bits [1:0] of the load
//   op    : load op code
//   data  : formatted 32-bit load result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  mem_op_e     op,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   data = {{24{b[7]}}, b};
      OP_LBU:  data = {24'b0, b};
      OP_LH:   data = {{16{h[15]}}, h};
      OP_LHU:  data = {16'b0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between execute and writeback.
//   in_*      : instruction from execute (held by upstream while busy)
//   busy      : stage has a memory transaction outstanding
//   mem_*     : data-memory req/ack handshake; req held until ack
//   out_*     : registered result to writeback; out_valid/out_exc are pulses
module mem_access
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_index,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_store,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic          out_sel,
  output logic [4:0]    out_index,
  output logic [DW-1:0] out_ex,
  output logic [DW-1:0] out_mem,
  output logic          out_exc
);

  state_e        state_q, state_d;
  mem_op_e       op_in, op_q;
  logic [1:0]    off_q;
  logic [4:0]    idx_q;
  logic          acc, misal;
  logic [DW-1:0] wdata_d;
  logic [3:0]    be_d;
  logic [31:0]   ld_data;

  assign op_in   = decode_op(in_op);
  assign acc     = is_load(op_in) | is_store(op_in);
  assign misal   = misaligned(op_in, in_alu[1:0]);
  assign busy    = (state_q == WAIT);
  assign mem_req = busy;

  // Store lanes: data is replicated so the byte enables alone pick the lane.
  always_comb begin
    wdata_d = in_store;
    be_d    = BE_ALL;
    case (op_in)
      OP_SB: begin
        wdata_d = {4{in_store[7:0]}};
        be_d    = BE_B0 << in_alu[1:0];
      end
      OP_SH: begin
        wdata_d = {2{in_store[15:0]}};
        be_d    = in_alu[1] ? BE_HI : BE_LO;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid && acc && !misal) state_d = WAIT;
      WAIT: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  load_align u_align (
    .rdata (mem_rdata),
    .off   (off_q),
    .op    (op_q),
    .data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      op_q      <= OP_NONE;
      off_q     <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      out_index <= '0;
      out_ex    <= '0;
      out_mem   <= '0;
      out_exc   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_exc   <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          if (acc && misal) begin
            out_exc <= 1'b1;
          end else if (acc) begin
            mem_we    <= is_store(op_in);
            mem_addr  <= {in_alu[AW-1:2], 2'b00};
            mem_wdata <= wdata_d;
            mem_be    <= be_d;
            op_q      <= op_in;
            off_q     <= in_alu[1:0];
            idx_q     <= in_index;
          end else begin
            out_valid <= 1'b1;
            out_sel   <= 1'b1;
            out_index <= in_index;
            out_ex    <= in_alu;
          end
        end
        WAIT: if (mem_ack && !mem_we) begin
          out_valid <= 1'b1;
          out_sel   <= 1'b0;
          out_index <= idx_q;
          out_mem   <= ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_index;
  logic [31:0] in_alu, in_store;
  logic        busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        out_valid, out_sel, out_exc;
  logic [4:0]  out_index;
  logic [31:0] out_ex, out_mem;

  mem_access #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
    .in_index(in_index), .in_alu(in_alu), .in_store(in_store),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_sel(out_sel),
    .out_index(out_index), .out_ex(out_ex), .out_mem(out_mem),
    .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic        sel;
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Monitor: every result/exception pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid || out_exc) begin
      if (q.size() == 0) begin
        chk("unexpected_result", {30'b0, out_valid, out_exc}, 32'h0);
      end else begin
        mon_e = q.pop_front();
        chk("res_exc", {31'b0, out_exc}, {31'b0, mon_e.exc});
        chk("res_valid", {31'b0, out_valid}, {31'b0, !mon_e.exc});
        if (!mon_e.exc) begin
          chk("res_sel", {31'b0, out_sel}, {31'b0, mon_e.sel});
          chk("res_index", {27'b0, out_index}, {27'b0, mon_e.idx});
          chk("res_data", mon_e.sel ? out_ex : out_mem, mon_e.data);
        end
      end
    end
  end

  task automatic alu_op(input logic [3:0] op, input logic [4:0] idx, input logic [31:0] alu);
    in_valid = 1; in_op = op; in_index = idx; in_alu = alu; in_store = '0;
    q.push_back('{exc: 1'b0, sel: 1'b1, idx: idx, data: alu});
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("alu_no_req", {31'b0, mem_req}, 32'h0);
    chk("alu_not_busy", {31'b0, busy}, 32'h0);
  endtask

  task automatic misal_op(input logic [3:0] op, input logic [31:0] addr);
    in_valid = 1; in_op = op; in_index = 5'd1; in_alu = addr; in_store = '0;
    q.push_back('{exc: 1'b1, sel: 1'b0, idx: 5'd0, data: 32'h0});
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("misal_no_req", {31'b0, mem_req}, 32'h0);
    chk("misal_not_busy", {31'b0, busy}, 32'h0);
  endtask

  // Memory op; ack is given in WAIT cycle n (n=1 => same cycle req rises).
  task automatic mem_txn(input logic [3:0] op, input logic [4:0] idx,
                         input logic [31:0] addr, input logic [31:0] store,
                         input int n, input logic [31:0] rdata,
                         input logic [31:0] x_addr, input logic x_we,
                         input logic [3:0] x_be, input logic [31:0] x_wdata,
                         input logic [31:0] x_data);
    int busy_cnt;
    busy_cnt = 0;
    in_valid = 1; in_op = op; in_index = idx; in_alu = addr; in_store = store;
    if (!x_we) q.push_back('{exc: 1'b0, sel: 1'b0, idx: idx, data: x_data});
    @(posedge clk); #1 in_valid = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      chk("wait_req", {31'b0, mem_req}, 32'h1);
      chk("wait_addr", mem_addr, x_addr);
      if (k == 1) begin
        chk("wait_we", {31'b0, mem_we}, {31'b0, x_we});
        if (x_we) begin
          chk("wait_be", {28'b0, mem_be}, {28'b0, x_be});
          chk("wait_wdata", mem_wdata, x_wdata);
        end
      end
      if (k == n) begin mem_ack = 1; mem_rdata = rdata; end
      @(posedge clk); #1 mem_ack = 0;
    end
    @(negedge clk);
    chk("busy_cycles", busy_cnt, n);
    chk("done_req_low", {31'b0, mem_req}, 32'h0);
    chk("done_not_busy", {31'b0, busy}, 32'h0);
    if (x_we) chk("store_no_valid", {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    rst = 0; in_valid = 0; in_op = 0; in_index = 0; in_alu = 0; in_store = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {26'b0, mem_req, busy, out_valid, out_exc, out_sel, mem_we}, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_out_ex", out_ex, 32'h0);
    @(posedge clk); #1 rst = 1;

    // ALU pass-through, and an unused op code behaving as NONE
    alu_op(4'h0, 5'd7, 32'h1234_5678);
    alu_op(4'hF, 5'd31, 32'h0000_A5A5);

    // Loads: LB signed, LBU, LH signed, LHU
    mem_txn(4'd1, 5'd2, 32'h103, 0, 3, 32'h80FF_0000, 32'h100, 0, 0, 0, 32'hFFFF_FF80);
    mem_txn(4'd4, 5'd3, 32'h102, 0, 2, 32'h80FF_0000, 32'h100, 0, 0, 0, 32'h0000_00FF);
    mem_txn(4'd2, 5'd4, 32'h202, 0, 1, 32'h80FF_0000, 32'h200, 0, 0, 0, 32'hFFFF_80FF);
    mem_txn(4'd5, 5'd5, 32'h200, 0, 2, 32'h1234_8001, 32'h200, 0, 0, 0, 32'h0000_8001);

    // Stores: SH upper half, SB lane 1, SW
    mem_txn(4'd7, 5'd6, 32'h22, 32'h0000_ABCD, 2, 0, 32'h20, 1, 4'b1100, 32'hABCD_ABCD, 0);
    mem_txn(4'd6, 5'd8, 32'h31, 32'h0000_01A5, 1, 0, 32'h30, 1, 4'b0010, 32'hA5A5_A5A5, 0);
    mem_txn(4'd8, 5'd9, 32'h44, 32'hCAFE_F00D, 1, 0, 32'h44, 1, 4'b1111, 32'hCAFE_F00D, 0);

    // Misaligned accesses
    misal_op(4'd3, 32'h6);
    misal_op(4'd7, 32'h23);

    // Same-cycle ack, then an ALU op held by upstream while busy
    in_valid = 1; in_op = 4'd3; in_index = 5'd3; in_alu = 32'h40;
    q.push_back('{exc: 1'b0, sel: 1'b0, idx: 5'd3, data: 32'hDEAD_BEEF});
    q.push_back('{exc: 1'b0, sel: 1'b1, idx: 5'd9, data: 32'h0000_0055});
    @(posedge clk); #1 in_op = 4'd0; in_index = 5'd9; in_alu = 32'h55;
    @(negedge clk);
    chk("b2b_busy", {31'b0, busy}, 32'h1);
    chk("b2b_addr", mem_addr, 32'h40);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 mem_ack = 0;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("b2b_idle", {31'b0, busy}, 32'h0);

    // Reset during WAIT, then a stray ack
    in_valid = 1; in_op = 4'd5; in_index = 5'd4; in_alu = 32'h12;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("rw_busy", {31'b0, busy}, 32'h1);
    rst = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rw_ctrl", {26'b0, mem_req, busy, out_valid, out_exc, out_sel, mem_we}, 32'h0);
    chk("rw_be", {28'b0, mem_be}, 32'h0);
    chk("rw_addr", mem_addr, 32'h0);
    chk("rw_out_ex", out_ex, 32'h0);
    chk("rw_out_mem", out_mem, 32'h0);
    chk("rw_index", {27'b0, out_index}, 32'h0);
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 mem_ack = 0;
    @(negedge clk);
    chk("stray_ack_req", {31'b0, mem_req}, 32'h0);
    chk("stray_ack_busy", {31'b0, busy}, 32'h0);

    // Stage still works after the abandoned transaction
    alu_op(4'h0, 5'd12, 32'h0BAD_F00D);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
